// File: rtl/game_tick_generator.sv
// Clock-enable strobes for the snake game: a free-running pixel strobe and a
// game-step strobe whose period follows a speed level, with pause and restart.
module game_tick_generator #(
   parameter int unsigned PixelDiv       = 4,
   parameter int unsigned CounterWidth   = 26,
   parameter int unsigned BasePeriod     = 50000000,
   parameter int unsigned StepPeriod     = 5000000,
   parameter int unsigned MinPeriod      = 10000000,
   parameter int unsigned LevelWidth     = 4,
   parameter int unsigned TickCountWidth = 16
) (
   input  logic                      MasterClock,
   input  logic                      ResetN,
   input  logic [LevelWidth-1:0]     Level,
   input  logic                      Pause,
   input  logic                      Restart,
   output logic                      PixelTick,
   output logic                      GameTick,
   output logic [TickCountWidth-1:0] TickCount,
   output logic                      Running
);

   localparam int unsigned PIX_W  = $clog2(PixelDiv);
   localparam int unsigned PROD_W = CounterWidth + LevelWidth + 1;

   localparam logic signed [PROD_W-1:0] BASE_S = PROD_W'(BasePeriod);
   localparam logic signed [PROD_W-1:0] STEP_S = PROD_W'(StepPeriod);
   localparam logic signed [PROD_W-1:0] MIN_S  = PROD_W'(MinPeriod);

   logic [PIX_W-1:0]         pix_cnt;
   logic [CounterWidth-1:0]  game_cnt;
   logic [CounterWidth-1:0]  active_period;
   logic [CounterWidth-1:0]  next_period;
   logic signed [PROD_W-1:0] lvl_s;
   logic signed [PROD_W-1:0] period_s;

   always_ff @(posedge MasterClock or negedge ResetN) begin
      if (!ResetN) begin
         pix_cnt   <= '0;
         PixelTick <= 1'b0;
      end else if (pix_cnt == PIX_W'(PixelDiv - 1)) begin
         pix_cnt   <= '0;
         PixelTick <= 1'b1;
      end else begin
         pix_cnt   <= pix_cnt + PIX_W'(1);
         PixelTick <= 1'b0;
      end
   end

   // Signed so that levels pushing the period below zero still clamp to MinPeriod.
   always_comb begin
      lvl_s    = $signed(PROD_W'(Level));
      period_s = BASE_S - lvl_s * STEP_S;
      if (period_s < MIN_S) begin
         period_s = MIN_S;
      end
      next_period = period_s[CounterWidth-1:0];
   end

   always_ff @(posedge MasterClock or negedge ResetN) begin
      if (!ResetN) begin
         game_cnt      <= '0;
         active_period <= CounterWidth'(BasePeriod);
         GameTick      <= 1'b0;
         TickCount     <= '0;
         Running       <= 1'b0;
      end else begin
         Running <= ~Pause & ~Restart;
         if (Restart) begin
            game_cnt      <= '0;
            TickCount     <= '0;
            active_period <= next_period;
            GameTick      <= 1'b0;
         end else if (Pause) begin
            GameTick <= 1'b0;
         end else if (game_cnt == active_period - CounterWidth'(1)) begin
            game_cnt      <= '0;
            GameTick      <= 1'b1;
            TickCount     <= TickCount + TickCountWidth'(1);
            active_period <= next_period;
         end else begin
            game_cnt <= game_cnt + CounterWidth'(1);
            GameTick <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_game_tick_generator.sv
// Self-checking bench for game_tick_generator: expected GameTick events are
// queued per scenario and matched against the DUT by a negedge monitor.
module tb_game_tick_generator;

   logic       MasterClock;
   logic       ResetN;
   logic [3:0] Level;
   logic       Pause;
   logic       Restart;
   logic       PixelTick;
   logic       GameTick;
   logic [3:0] TickCount;
   logic       Running;

   typedef struct {
      int         at;
      logic [3:0] count;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   tests_run = 0;
   int   failed    = 0;
   int   edge_no   = 0;
   bit   mon_en    = 0;

   game_tick_generator #(
      .PixelDiv(4),
      .CounterWidth(8),
      .BasePeriod(20),
      .StepPeriod(4),
      .MinPeriod(6),
      .LevelWidth(4),
      .TickCountWidth(4)
   ) dut (
      .MasterClock(MasterClock),
      .ResetN(ResetN),
      .Level(Level),
      .Pause(Pause),
      .Restart(Restart),
      .PixelTick(PixelTick),
      .GameTick(GameTick),
      .TickCount(TickCount),
      .Running(Running)
   );

   initial MasterClock = 1'b0;
   always #5 MasterClock = ~MasterClock;

   // Rising edges since the last reset release.
   always @(posedge MasterClock or negedge ResetN) begin
      if (!ResetN) edge_no <= 0;
      else         edge_no <= edge_no + 1;
   end

   always @(negedge MasterClock) begin
      if (mon_en) begin
         tests_run++;
         if (PixelTick !== ((edge_no > 0) && (edge_no % 4 == 0))) begin
            failed++;
            $display("FAIL pixel_tick edge=%0d got=%b exp=%b", edge_no, PixelTick,
                     (edge_no > 0) && (edge_no % 4 == 0));
         end
         if (GameTick !== 1'b0) begin
            tests_run++;
            if (sb.size() == 0) begin
               failed++;
               $display("FAIL game_tick_unexpected edge=%0d got=%b exp=0", edge_no, GameTick);
            end else begin
               e = sb.pop_front();
               if (e.at != edge_no || TickCount !== e.count) begin
                  failed++;
                  $display("FAIL game_tick edge got=%0d exp=%0d count got=%0d exp=%0d",
                           edge_no, e.at, TickCount, e.count);
               end
            end
         end else if (sb.size() != 0 && sb[0].at <= edge_no) begin
            tests_run++;
            failed++;
            $display("FAIL game_tick_missed got=no tick at edge %0d exp=tick", sb[0].at);
            void'(sb.pop_front());
         end
      end
   end

   task automatic goto_edge(input int k);
      int guard = 0;
      while (edge_no < k) begin
         @(posedge MasterClock);
         #1;
         guard++;
         if (guard > 2000) begin
            tests_run++;
            failed++;
            $display("FAIL goto_edge_timeout got=%0d exp=%0d", edge_no, k);
            break;
         end
      end
   endtask

   task automatic do_reset(input logic [3:0] lvl);
      ResetN  = 1'b0;
      Pause   = 1'b0;
      Restart = 1'b0;
      Level   = lvl;
      repeat (2) @(posedge MasterClock);
      #2;
      sb.delete();
      ResetN = 1'b1;
   endtask

   task automatic check_drained(input string name);
      goto_edge(edge_no + 1);
      tests_run++;
      if (sb.size() != 0) begin
         failed++;
         $display("FAIL %s_drained got=%0d pending exp=0", name, sb.size());
      end
   endtask

   task automatic test_reset;
      ResetN  = 1'b0;
      Level   = 4'd0;
      Pause   = 1'b0;
      Restart = 1'b0;
      repeat (3) @(posedge MasterClock);
      #1;
      tests_run++;
      if ({PixelTick, GameTick, TickCount, Running} !== 7'b0) begin
         failed++;
         $display("FAIL reset_outputs got=%b exp=0", {PixelTick, GameTick, TickCount, Running});
      end
      mon_en = 1'b1;
   endtask

   task automatic test_basic;
      do_reset(4'd0);
      sb.push_back('{20, 4'd1});
      sb.push_back('{40, 4'd2});
      tests_run++;
      if (Running !== 1'b0) begin
         failed++;
         $display("FAIL running_before_edge1 got=%b exp=0", Running);
      end
      goto_edge(1);
      tests_run++;
      if (Running !== 1'b1) begin
         failed++;
         $display("FAIL running_edge1 got=%b exp=1", Running);
      end
      goto_edge(45);
      check_drained("basic");
   endtask

   task automatic test_level_change;
      do_reset(4'd0);
      sb.push_back('{20, 4'd1});
      sb.push_back('{28, 4'd2});
      sb.push_back('{36, 4'd3});
      goto_edge(10);
      Level = 4'd3;
      goto_edge(40);
      check_drained("level_change");
   endtask

   task automatic test_clamp_wrap;
      do_reset(4'd15);
      for (int k = 0; k < 17; k++) sb.push_back('{20 + 6 * k, 4'(k + 1)});
      goto_edge(118);
      check_drained("clamp_wrap");
   endtask

   task automatic test_pause;
      do_reset(4'd0);
      sb.push_back('{27, 4'd1});
      goto_edge(4);
      tests_run++;
      if (Running !== 1'b1) begin
         failed++;
         $display("FAIL pause_running_e4 got=%b exp=1", Running);
      end
      Pause = 1'b1;
      goto_edge(5);
      tests_run++;
      if (Running !== 1'b0) begin
         failed++;
         $display("FAIL pause_running_e5 got=%b exp=0", Running);
      end
      goto_edge(11);
      tests_run++;
      if (Running !== 1'b0) begin
         failed++;
         $display("FAIL pause_running_e11 got=%b exp=0", Running);
      end
      Pause = 1'b0;
      goto_edge(12);
      tests_run++;
      if (Running !== 1'b1) begin
         failed++;
         $display("FAIL pause_running_e12 got=%b exp=1", Running);
      end
      goto_edge(32);
      check_drained("pause");
   endtask

   task automatic test_restart_in_pause;
      do_reset(4'd15);
      sb.push_back('{20, 4'd1});
      sb.push_back('{26, 4'd2});
      sb.push_back('{32, 4'd3});
      sb.push_back('{64, 4'd1});
      goto_edge(34);
      tests_run++;
      if (TickCount !== 4'd3) begin
         failed++;
         $display("FAIL restart_pre_count got=%0d exp=3", TickCount);
      end
      Pause = 1'b1;
      goto_edge(38);
      Level   = 4'd0;
      Restart = 1'b1;
      goto_edge(39);
      tests_run++;
      if (TickCount !== 4'd0 || GameTick !== 1'b0 || Running !== 1'b0) begin
         failed++;
         $display("FAIL restart_clear got=%0d/%b/%b exp=0/0/0", TickCount, GameTick, Running);
      end
      Restart = 1'b0;
      goto_edge(44);
      Pause = 1'b0;
      goto_edge(70);
      check_drained("restart");
   endtask

   task automatic test_async_reset;
      do_reset(4'd0);
      sb.push_back('{20, 4'd1});
      goto_edge(33);
      tests_run++;
      if (TickCount !== 4'd1 || Running !== 1'b1) begin
         failed++;
         $display("FAIL async_pre got=%0d/%b exp=1/1", TickCount, Running);
      end
      #2;
      ResetN = 1'b0;
      #1;
      tests_run++;
      if ({PixelTick, GameTick, TickCount, Running} !== 7'b0) begin
         failed++;
         $display("FAIL async_reset_outputs got=%b exp=0", {PixelTick, GameTick, TickCount, Running});
      end
      do_reset(4'd5);
      sb.push_back('{20, 4'd1});
      sb.push_back('{26, 4'd2});
      goto_edge(30);
      check_drained("async_reset");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_level_change();
      test_clamp_wrap();
      test_pause();
      test_restart_in_pause();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
